// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: two-entry skid buffer that selects and captures arithmetic operands.
// Optional writeback bypass into captured and held operands is enabled by OPERAND_FORWARDING_EN.
module id_ex_operand_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rs1_addr,
    input  logic [4:0]      in_rs2_addr,
    input  logic [4:0]      in_rd_addr,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_use_pc,
    input  logic            in_use_imm,
    input  logic [1:0]      in_sel,
    input  logic            flush,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] operand_a,
    output logic [XLEN-1:0] operand_b,
    output logic [1:0]      arith_sel,
    output logic [4:0]      out_rd_addr
);

    localparam int unsigned REG_AW = 5;
    localparam int unsigned SEL_W  = 2;

    typedef struct packed {
        logic [XLEN-1:0]   a;
        logic [XLEN-1:0]   b;
        logic [SEL_W-1:0]  sel;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              a_rs;
        logic              b_rs;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;
    entry_t main_q, skid_q, cap, main_fwd, skid_fwd;
    logic   accept, deliver;
    logic   ld_main_in, ld_main_skid, ld_skid;
    logic   in_ready_d, out_valid_d;
    logic   wb_hit1, wb_hit2;
    logic [XLEN-1:0] rs1_val, rs2_val;

    assign accept  = in_valid && in_ready;
    assign deliver = out_valid && out_ready;

`ifdef OPERAND_FORWARDING_EN
    function automatic entry_t fwd(entry_t e, logic v, logic [REG_AW-1:0] rd, logic [XLEN-1:0] d);
        fwd = e;
        if (v && (rd != REG_AW'(0))) begin
            if (e.a_rs && (e.rs1 == rd)) fwd.a = d;
            if (e.b_rs && (e.rs2 == rd)) fwd.b = d;
        end
    endfunction

    assign wb_hit1  = wb_valid && (wb_rd_addr != REG_AW'(0)) && (wb_rd_addr == in_rs1_addr);
    assign wb_hit2  = wb_valid && (wb_rd_addr != REG_AW'(0)) && (wb_rd_addr == in_rs2_addr);
    assign main_fwd = fwd(main_q, wb_valid, wb_rd_addr, wb_data);
    assign skid_fwd = fwd(skid_q, wb_valid, wb_rd_addr, wb_data);
`else
    logic unused_wb;
    assign unused_wb = ^{wb_valid, wb_rd_addr, wb_data};
    assign wb_hit1   = 1'b0;
    assign wb_hit2   = 1'b0;
    assign main_fwd  = main_q;
    assign skid_fwd  = skid_q;
`endif

    // x0 always reads zero, ahead of any bypass
    assign rs1_val = (in_rs1_addr == REG_AW'(0)) ? XLEN'(0) : (wb_hit1 ? wb_data : in_rs1_data);
    assign rs2_val = (in_rs2_addr == REG_AW'(0)) ? XLEN'(0) : (wb_hit2 ? wb_data : in_rs2_data);

    always_comb begin
        cap      = '0;
        cap.a    = in_use_pc  ? in_pc  : rs1_val;
        cap.b    = in_use_imm ? in_imm : rs2_val;
        cap.sel  = in_sel;
        cap.rd   = in_rd_addr;
        cap.rs1  = in_rs1_addr;
        cap.rs2  = in_rs2_addr;
        cap.a_rs = !in_use_pc;
        cap.b_rs = !in_use_imm;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = ONE;
            ONE:     if (accept && !deliver) state_d = FULL;
                     else if (!accept && deliver) state_d = EMPTY;
            FULL:    if (deliver) state_d = ONE;
            default: state_d = EMPTY;
        endcase
        if (flush) state_d = EMPTY;
    end

    always_comb begin
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        in_ready_d   = (state_d != FULL);
        out_valid_d  = (state_d != EMPTY);
        if (!flush) begin
            case (state_q)
                EMPTY:   ld_main_in = accept;
                ONE: begin
                    ld_main_in = accept && deliver;
                    ld_skid    = accept && !deliver;
                end
                FULL:    ld_main_skid = deliver;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            main_q    <= '0;
            skid_q    <= '0;
        end else begin
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            if (ld_main_in)        main_q <= cap;
            else if (ld_main_skid) main_q <= skid_fwd;
            else                   main_q <= main_fwd;
            if (ld_skid) skid_q <= cap;
            else         skid_q <= skid_fwd;
        end
    end

    assign operand_a   = main_q.a;
    assign operand_b   = main_q.b;
    assign arith_sel   = main_q.sel;
    assign out_rd_addr = main_q.rd;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage; reference model honours OPERAND_FORWARDING_EN.
module tb_id_ex_operand_stage;

`ifdef OPERAND_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk, rst_n;
    logic        in_valid, in_ready;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [31:0] in_rs1_data, in_rs2_data, in_pc, in_imm;
    logic        in_use_pc, in_use_imm;
    logic [1:0]  in_sel;
    logic        flush;
    logic        wb_valid;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_data;
    logic        out_valid, out_ready;
    logic [31:0] operand_a, operand_b;
    logic [1:0]  arith_sel;
    logic [4:0]  out_rd_addr;

    id_ex_operand_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_pc(in_pc), .in_imm(in_imm),
        .in_use_pc(in_use_pc), .in_use_imm(in_use_imm), .in_sel(in_sel),
        .flush(flush),
        .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .operand_a(operand_a), .operand_b(operand_b),
        .arith_sel(arith_sel), .out_rd_addr(out_rd_addr)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        bit          a_rs;
        bit          b_rs;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   delivered = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] src(input logic [4:0] addr, input logic [31:0] data);
        if (addr == 5'd0) return 32'h0;
        if (FWD && wb_valid && wb_rd_addr == addr) return wb_data;
        return data;
    endfunction

    function automatic exp_t model();
        exp_t e;
        e.a    = in_use_pc  ? in_pc  : src(in_rs1_addr, in_rs1_data);
        e.b    = in_use_imm ? in_imm : src(in_rs2_addr, in_rs2_data);
        e.sel  = in_sel;
        e.rd   = in_rd_addr;
        e.rs1  = in_rs1_addr;
        e.rs2  = in_rs2_addr;
        e.a_rs = !in_use_pc;
        e.b_rs = !in_use_imm;
        return e;
    endfunction

    // Monitor: compare each delivery, then apply flush and writeback to what remains held
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_delivery a=%h b=%h sel=%0d rd=%0d required=none",
                             operand_a, operand_b, arith_sel, out_rd_addr);
                end else begin
                    mon_e = sb.pop_front();
                    delivered++;
                    if (operand_a !== mon_e.a || operand_b !== mon_e.b ||
                        arith_sel !== mon_e.sel || out_rd_addr !== mon_e.rd) begin
                        bad++;
                        $display("FAIL delivery actual a=%h b=%h sel=%0d rd=%0d required a=%h b=%h sel=%0d rd=%0d",
                                 operand_a, operand_b, arith_sel, out_rd_addr,
                                 mon_e.a, mon_e.b, mon_e.sel, mon_e.rd);
                    end
                end
            end
            if (flush) sb.delete();
            else if (FWD && wb_valid && wb_rd_addr != 5'd0) begin
                foreach (sb[i]) begin
                    if (sb[i].a_rs && sb[i].rs1 == wb_rd_addr) sb[i].a = wb_data;
                    if (sb[i].b_rs && sb[i].rs2 == wb_rd_addr) sb[i].b = wb_data;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step(output bit acc);
        @(negedge clk);
        acc = rst_n && in_valid && in_ready && !flush;
        if (acc) sb.push_back(model());
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input bit v, input logic [4:0] r1a, input logic [31:0] r1d,
                          input logic [4:0] r2a, input logic [31:0] r2d, input logic [4:0] rd,
                          input logic [31:0] pc, input logic [31:0] imm,
                          input bit upc, input bit uimm, input logic [1:0] sel);
        in_valid = v; in_rs1_addr = r1a; in_rs1_data = r1d; in_rs2_addr = r2a; in_rs2_data = r2d;
        in_rd_addr = rd; in_pc = pc; in_imm = imm; in_use_pc = upc; in_use_imm = uimm; in_sel = sel;
    endtask

    bit acc;
    int d0, n_acc;

    initial begin
        rst_n = 1'b1; flush = 1'b0; out_ready = 1'b0;
        wb_valid = 1'b0; wb_rd_addr = 5'd0; wb_data = 32'h0;
        set_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #12;
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_in_ready", 32'(in_ready), 32'h0);
        chk("reset_operand_a", operand_a, 32'h0);
        chk("reset_operand_b", operand_b, 32'h0);
        chk("reset_arith_sel", 32'(arith_sel), 32'h0);
        chk("reset_rd", 32'(out_rd_addr), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        chk("release_in_ready", 32'(in_ready), 32'h1);

        // single op
        out_ready = 1'b1;
        set_op(1, 5'd1, 32'd5, 5'd2, 32'd3, 5'd3, 32'h0, 32'h0, 0, 0, 2'b01);
        step(acc);
        in_valid = 1'b0;
        chk("single_out_valid", 32'(out_valid), 32'h1);
        chk("single_operand_a", operand_a, 32'd5);
        chk("single_operand_b", operand_b, 32'd3);
        chk("single_arith_sel", 32'(arith_sel), 32'h1);
        step(acc);

        // backpressure A,B accepted, C waits
        d0 = delivered;
        out_ready = 1'b0;
        set_op(1, 5'd1, 32'hA1, 5'd2, 32'hA2, 5'd10, 0, 0, 0, 0, 2'b00); step(acc);
        set_op(1, 5'd3, 32'hB1, 5'd4, 32'hB2, 5'd11, 0, 0, 0, 0, 2'b10); step(acc);
        set_op(1, 5'd5, 32'hC1, 5'd6, 32'hC2, 5'd12, 0, 0, 0, 0, 2'b11);
        chk("bp_in_ready_full", 32'(in_ready), 32'h0);
        out_ready = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) step(acc);
        chk("bp_c_accepted", 32'(acc), 32'h1);
        in_valid = 1'b0;
        repeat (4) step(acc);
        chk("bp_delivered", 32'(delivered - d0), 32'd3);

        // PC / immediate selection, then x0 with a bypass aimed at x0
        set_op(1, 5'd1, 32'h1234, 5'd2, 32'h5678, 5'd4, 32'h1000, 32'hFFFF_FFFC, 1, 1, 2'b00);
        step(acc);
        in_valid = 1'b0;
        chk("pc_operand_a", operand_a, 32'h1000);
        chk("imm_operand_b", operand_b, 32'hFFFF_FFFC);
        step(acc);
        set_op(1, 5'd0, 32'hDEAD, 5'd2, 32'h9, 5'd5, 0, 0, 0, 0, 2'b10);
        wb_valid = 1'b1; wb_rd_addr = 5'd0; wb_data = 32'hBEEF;
        step(acc);
        in_valid = 1'b0; wb_valid = 1'b0;
        chk("x0_operand_a", operand_a, 32'h0);
        step(acc);

        // throughput with out_ready held high
        n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            set_op(1, 5'(i + 1), $urandom, 5'(i + 2), $urandom, 5'(i), 0, 0, 0, 0, 2'(i));
            step(acc);
            if (acc) n_acc++;
        end
        in_valid = 1'b0;
        chk("throughput_accepts", 32'(n_acc), 32'd8);
        repeat (2) step(acc);

        // flush while FULL, with an instruction on offer
        out_ready = 1'b0;
        set_op(1, 5'd1, 32'h11, 5'd2, 32'h22, 5'd7, 0, 0, 0, 0, 2'b01); step(acc);
        set_op(1, 5'd3, 32'h33, 5'd4, 32'h44, 5'd8, 0, 0, 0, 0, 2'b01); step(acc);
        chk("flush_pre_full", 32'(in_ready), 32'h0);
        set_op(1, 5'd5, 32'hF1, 5'd6, 32'hF2, 5'd9, 0, 0, 0, 0, 2'b11);
        flush = 1'b1;
        step(acc);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'h0);
        chk("flush_in_ready", 32'(in_ready), 32'h1);
        out_ready = 1'b1;
        repeat (3) step(acc);
        chk("flush_nothing_emerges", 32'(out_valid), 32'h0);

        // writeback into a held operand
        out_ready = 1'b0;
        set_op(1, 5'd7, 32'h11, 5'd3, 32'h22, 5'd6, 0, 0, 0, 0, 2'b00);
        step(acc);
        in_valid = 1'b0;
        wb_valid = 1'b1; wb_rd_addr = 5'd7; wb_data = 32'h42;
        step(acc);
        wb_valid = 1'b0;
        chk("fwd_held_operand_a", operand_a, FWD ? 32'h42 : 32'h11);
        chk("fwd_held_operand_b", operand_b, 32'h22);
        out_ready = 1'b1;
        repeat (2) step(acc);

        // reset mid-transfer discards both entries
        out_ready = 1'b0;
        set_op(1, 5'd1, 32'h77, 5'd2, 32'h88, 5'd3, 0, 0, 0, 0, 2'b11); step(acc);
        set_op(1, 5'd1, 32'h99, 5'd2, 32'hAA, 5'd4, 0, 0, 0, 0, 2'b10); step(acc);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("midrst_out_valid", 32'(out_valid), 32'h0);
        chk("midrst_operand_a", operand_a, 32'h0);
        chk("midrst_arith_sel", 32'(arith_sel), 32'h0);
        chk("midrst_in_ready", 32'(in_ready), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        chk("midrst_release_in_ready", 32'(in_ready), 32'h1);
        out_ready = 1'b1;
        repeat (2) step(acc);
        chk("midrst_nothing_emerges", 32'(out_valid), 32'h0);

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            set_op($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                   5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 31)),
                   $urandom, $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                   2'($urandom_range(0, 3)));
            flush      = ($urandom_range(0, 24) == 0);
            out_ready  = ($urandom_range(0, 9) < 7);
            wb_valid   = $urandom_range(0, 1) == 1;
            wb_rd_addr = 5'($urandom_range(0, 7));
            wb_data    = $urandom;
            step(acc);
        end
        set_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        flush = 1'b0; wb_valid = 1'b0; out_ready = 1'b1;
        repeat (5) step(acc);
        chk("drain_scoreboard_empty", 32'(sb.size()), 32'h0);
        chk("drain_out_valid", 32'(out_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
ID_EX_OPERAND_STAGE -- requirements
Module: id_ex_operand_stage

Interface
REQ-001 Parameter: XLEN, 32, datapath width; only 32 is supported.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid/in_ready  input/output  1/1  decode-side handshake.
REQ-005 in_rs1_addr, in_rs2_addr, in_rd_addr  input  5 each  register indices.
REQ-006 in_rs1_data, in_rs2_data  input  32 each  register-file read data.
REQ-007 in_pc, in_imm  input  32 each  instruction PC and sign-extended immediate.
REQ-008 in_use_pc, in_use_imm  input  1 each  select PC for A, immediate for B.
REQ-009 in_sel  input  2  arithmetic op: 00 ADD, 01 SUB, 10 SLT, 11 SLTU.
REQ-010 flush  input  1  discard all held and incoming instructions.
REQ-011 wb_valid, wb_rd_addr, wb_data  input  1/5/32  writeback bypass port.
REQ-012 out_valid/out_ready  output/input  1/1  execute-side handshake.
REQ-013 operand_a, operand_b, arith_sel, out_rd_addr  output  32/32/2/5  operands and op for the arithmetic unit, destination index.

Function
REQ-014 Accept when in_valid&&in_ready; deliver when out_valid&&out_ready; both on the same clk edge.
REQ-015 Two entries (main, skid); states EMPTY (none), ONE (main), FULL (main+skid).
REQ-016 EMPTY: accept -> ONE.
REQ-017 ONE: accept without deliver -> FULL; deliver without accept -> EMPTY; both or neither -> ONE, main replaced by new entry when both.
REQ-018 FULL: deliver -> ONE, skid moves to main; no accept in FULL.
REQ-019 in_ready is a register output, 1 in EMPTY/ONE, 0 in FULL; no combinational path out_ready->in_ready.
REQ-020 out_valid = 1 in ONE/FULL; outputs always driven from main entry, held stable while out_valid&&!out_ready.
REQ-021 Capture: operand_a = in_use_pc ? in_pc : rs1 value; operand_b = in_use_imm ? in_imm : rs2 value; arith_sel = in_sel; 32-bit values unmodified.
REQ-022 Register index 0 reads as 32'h0 regardless of in_rsN_data or bypass.
REQ-023 Latency: an instruction accepted at edge N presents out_valid after edge N when the stage was EMPTY.
REQ-024 flush: at the next edge state -> EMPTY, in_ready -> 1; an instruction offered that cycle is dropped; delivery on that cycle still counts if out_valid&&out_ready.
REQ-025 Throughput: one instruction per cycle sustained when out_ready is held 1.
REQ-026 Outputs with out_valid=0 hold their last values; the bench shall check them only when out_valid=1.

Reset
REQ-027 rst_n low: state EMPTY, in_ready=0 while asserted, then 1 at the first edge after deassertion; out_valid=0; operand_a, operand_b=32'h0; arith_sel=2'b00; out_rd_addr=5'h0.
REQ-028 Reset asserted mid-transfer discards both entries; no partial instruction emerges.

Configuration
REQ-029 Macro OPERAND_FORWARDING_EN defined: on capture, if wb_valid && wb_rd_addr!=0 && wb_rd_addr==in_rsN_addr, rsN value = wb_data; additionally every held entry whose operand came from rsN (use flag clear) is overwritten with wb_data on a matching wb_valid cycle.
REQ-030 Macro undefined: wb_* inputs are ignored; operands come only from in_rsN_data/in_pc/in_imm; held entries never change.

Verification
REQ-031 Reset: rst_n=0 mid-stream -> out_valid=0, operand_a=0, arith_sel=00; first edge after release -> in_ready=1.
REQ-032 Single op: rs1_data=5, rs2_data=3, sel=01, out_ready=1 -> next cycle out_valid=1, operand_a=5, operand_b=3, arith_sel=01.
REQ-033 Backpressure: out_ready=0, offer three ops A,B,C -> A,B accepted, in_ready=0 for C; release out_ready -> A,B,C delivered in order, none lost/duplicated.
REQ-034 Immediate/PC/x0: in_use_pc=1, pc=32'h1000, in_use_imm=1, imm=32'hFFFF_FFFC -> operand_a=32'h1000, operand_b=32'hFFFF_FFFC; rs1_addr=0 with rs1_data=32'hDEAD -> operand_a=0.
REQ-035 Flush in FULL: out_ready=0, two held ops, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed input never appears.
REQ-036 Forwarding (macro defined): op held with rs1_addr=7, out_ready=0; wb_valid=1, wb_rd_addr=7, wb_data=32'h42 -> operand_a=32'h42; macro undefined -> operand_a unchanged.
